// File: rtl/flags_pkg.sv
// flags_pkg: shared constants for the 8086 FLAGS register slice.
//   - FLAGS bit positions
//   - reserved-bit masks and a helper that forces them
//   - flag command encodings
//   - single-step trap state encodings
package flags_pkg;

  // FLAGS bit positions
  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int AF_BIT = 4;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int TF_BIT = 8;
  localparam int IF_BIT = 9;
  localparam int DF_BIT = 10;
  localparam int OF_BIT = 11;

  // Reserved bits: 15:12 and 1 always read 1, bits 5 and 3 always read 0
  localparam logic [15:0] RSV_ONE_MASK  = 16'hF002;
  localparam logic [15:0] RSV_ZERO_MASK = 16'h0028;

  // Bits written by SAHF: SF, ZF, AF, PF, CF
  localparam logic [15:0] SAHF_MASK = 16'h00D5;

  // Flag command encodings
  localparam logic [2:0] CMD_CLC       = 3'd0;
  localparam logic [2:0] CMD_STC       = 3'd1;
  localparam logic [2:0] CMD_CMC       = 3'd2;
  localparam logic [2:0] CMD_CLI       = 3'd3;
  localparam logic [2:0] CMD_STI       = 3'd4;
  localparam logic [2:0] CMD_CLD       = 3'd5;
  localparam logic [2:0] CMD_STD       = 3'd6;
  localparam logic [2:0] CMD_INT_ENTRY = 3'd7;

  // Single-step trap states
  localparam logic [1:0] TRAP_IDLE  = 2'd0;
  localparam logic [1:0] TRAP_ARMED = 2'd1;
  localparam logic [1:0] TRAP_REQ   = 2'd2;

  // Apply the fixed values of the reserved bits to a candidate FLAGS word
  function automatic logic [15:0] force_reserved(input logic [15:0] word);
    return (word & ~(RSV_ONE_MASK | RSV_ZERO_MASK)) | RSV_ONE_MASK;
  endfunction

endpackage

// File: rtl/flags_evt_ctl.sv
// flags_evt_ctl: interrupt-shadow counter and single-step trap sequencer.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   if_rise      IF goes 0->1 at this edge (starts shadow)
//   ss_we        MOV/POP SS executed (starts shadow)
//   tf           current registered TF, sampled at instruction boundaries
//   instr_end    instruction boundary pulse
//   int_entry    INT_ENTRY command (cancels an armed trap)
//   trap_ack     sequencer accepted the trap request
//   shadow_zero  shadow counter is zero (registered)
//   trap_req     single-step trap pending (registered)
module flags_evt_ctl
  import flags_pkg::*;
#(
  parameter int SHADOW_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_rise,
  input  logic ss_we,
  input  logic tf,
  input  logic instr_end,
  input  logic int_entry,
  input  logic trap_ack,
  output logic shadow_zero,
  output logic trap_req
);

  localparam int CNT_W = (SHADOW_LEN < 1) ? 1 : $clog2(SHADOW_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SHADOW_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] shadow_cnt_r;
  logic [CNT_W-1:0] shadow_cnt_nxt_s;
  logic [1:0]       trap_state_r;
  logic [1:0]       trap_state_nxt_s;
  logic             shadow_zero_r;
  logic             trap_req_r;

  // Shadow counter next value: a new shadow event beats a coincident boundary
  always_comb begin
    shadow_cnt_nxt_s = shadow_cnt_r;
    if (if_rise || ss_we) begin
      shadow_cnt_nxt_s = CNT_LOAD;
    end else if (instr_end && (shadow_cnt_r != CNT_ZERO)) begin
      shadow_cnt_nxt_s = shadow_cnt_r - CNT_ONE;
    end else begin
      shadow_cnt_nxt_s = shadow_cnt_r;
    end
  end

  // Trap FSM next state; ARMED fires on the next boundary regardless of TF
  always_comb begin
    trap_state_nxt_s = trap_state_r;
    case (trap_state_r)
      TRAP_IDLE: begin
        if (instr_end && tf) begin
          trap_state_nxt_s = TRAP_ARMED;
        end else begin
          trap_state_nxt_s = TRAP_IDLE;
        end
      end
      TRAP_ARMED: begin
        if (int_entry) begin
          trap_state_nxt_s = TRAP_IDLE;
        end else if (instr_end) begin
          trap_state_nxt_s = TRAP_REQ;
        end else begin
          trap_state_nxt_s = TRAP_ARMED;
        end
      end
      TRAP_REQ: begin
        if (trap_ack) begin
          trap_state_nxt_s = TRAP_IDLE;
        end else begin
          trap_state_nxt_s = TRAP_REQ;
        end
      end
      default: begin
        trap_state_nxt_s = TRAP_IDLE;
      end
    endcase
  end

  // State registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_cnt_r  <= CNT_ZERO;
      trap_state_r  <= TRAP_IDLE;
      shadow_zero_r <= 1'b1;
      trap_req_r    <= 1'b0;
    end else begin
      shadow_cnt_r  <= shadow_cnt_nxt_s;
      trap_state_r  <= trap_state_nxt_s;
      shadow_zero_r <= (shadow_cnt_nxt_s == CNT_ZERO);
      trap_req_r    <= (trap_state_nxt_s == TRAP_REQ);
    end
  end

  assign shadow_zero = shadow_zero_r;
  assign trap_req    = trap_req_r;

endmodule

// File: rtl/flags_reg.sv
// flags_reg: 8086 FLAGS register. Merges ALU updates, POPF/IRET loads, SAHF
// and flag commands into one register, and exposes the condition-code vector,
// the interrupt enable (gated by the STI / MOV SS shadow) and the single-step
// trap request.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   alu_we/alu_flags/alu_mask  masked ALU update of {of,sf,zf,af,pf,cf}
//   load_we/load_word     full word load (POPF, IRET)
//   sahf_we/sahf_byte     load SF,ZF,AF,PF,CF from AH
//   cmd_v/cmd             CLC..STD, INT_ENTRY
//   ss_we                 MOV/POP SS executed
//   instr_end             instruction boundary pulse
//   trap_ack              trap request accepted
//   flags                 architectural FLAGS (registered)
//   logic_flags           {of,sf,zf,pf,cf}
//   intr_en               IF set and no shadow active
//   trap_req              single-step trap pending
module flags_reg
  import flags_pkg::*;
#(
  parameter logic [15:0] RST_FLAGS  = 16'hF002,
  parameter int          SHADOW_LEN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_we,
  input  logic [5:0]  alu_flags,
  input  logic [5:0]  alu_mask,
  input  logic        load_we,
  input  logic [15:0] load_word,
  input  logic        sahf_we,
  input  logic [7:0]  sahf_byte,
  input  logic        cmd_v,
  input  logic [2:0]  cmd,
  input  logic        ss_we,
  input  logic        instr_end,
  input  logic        trap_ack,
  output logic [15:0] flags,
  output logic [4:0]  logic_flags,
  output logic        intr_en,
  output logic        trap_req
);

  logic [15:0] flags_r;
  logic [15:0] cmd_word_s;
  logic [15:0] alu_pos_mask_s;
  logic [15:0] alu_pos_word_s;
  logic [15:0] alu_word_s;
  logic [15:0] sahf_word_s;
  logic [15:0] flags_nxt_s;
  logic        if_rise_s;
  logic        int_entry_s;
  logic        shadow_zero_s;

  // Lowest-priority stage: flag commands act on the current register value
  always_comb begin
    cmd_word_s = flags_r;
    if (cmd_v) begin
      case (cmd)
        CMD_CLC: cmd_word_s[CF_BIT] = 1'b0;
        CMD_STC: cmd_word_s[CF_BIT] = 1'b1;
        CMD_CMC: cmd_word_s[CF_BIT] = ~flags_r[CF_BIT];
        CMD_CLI: cmd_word_s[IF_BIT] = 1'b0;
        CMD_STI: cmd_word_s[IF_BIT] = 1'b1;
        CMD_CLD: cmd_word_s[DF_BIT] = 1'b0;
        CMD_STD: cmd_word_s[DF_BIT] = 1'b1;
        CMD_INT_ENTRY: begin
          cmd_word_s[IF_BIT] = 1'b0;
          cmd_word_s[TF_BIT] = 1'b0;
        end
        default: cmd_word_s = flags_r;
      endcase
    end else begin
      cmd_word_s = flags_r;
    end
  end

  // Scatter the 6-bit ALU vector {of,sf,zf,af,pf,cf} onto FLAGS positions
  assign alu_pos_mask_s = {4'b0000, alu_mask[5], 3'b000, alu_mask[4], alu_mask[3], 1'b0,
                           alu_mask[2], 1'b0, alu_mask[1], 1'b0, alu_mask[0]};
  assign alu_pos_word_s = {4'b0000, alu_flags[5], 3'b000, alu_flags[4], alu_flags[3], 1'b0,
                           alu_flags[2], 1'b0, alu_flags[1], 1'b0, alu_flags[0]};

  // Higher-priority writers overlay lower ones bit by bit
  assign alu_word_s  = alu_we ? ((cmd_word_s & ~alu_pos_mask_s) | (alu_pos_word_s & alu_pos_mask_s))
                              : cmd_word_s;
  assign sahf_word_s = sahf_we ? ((alu_word_s & ~SAHF_MASK) | ({8'h00, sahf_byte} & SAHF_MASK))
                               : alu_word_s;
  assign flags_nxt_s = force_reserved(load_we ? load_word : sahf_word_s);

  assign if_rise_s   = ~flags_r[IF_BIT] & flags_nxt_s[IF_BIT];
  assign int_entry_s = cmd_v & (cmd == CMD_INT_ENTRY);

  // FLAGS register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r <= RST_FLAGS;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  flags_evt_ctl #(
    .SHADOW_LEN (SHADOW_LEN)
  ) u_evt_ctl (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_rise     (if_rise_s),
    .ss_we       (ss_we),
    .tf          (flags_r[TF_BIT]),
    .instr_end   (instr_end),
    .int_entry   (int_entry_s),
    .trap_ack    (trap_ack),
    .shadow_zero (shadow_zero_s),
    .trap_req    (trap_req)
  );

  assign flags       = flags_r;
  assign logic_flags = {flags_r[OF_BIT], flags_r[SF_BIT], flags_r[ZF_BIT], flags_r[PF_BIT], flags_r[CF_BIT]};
  assign intr_en     = flags_r[IF_BIT] & shadow_zero_s;

endmodule
